// File: rtl/tetris_input_pkg.sv
// Shared command/state encoding, key codes and FSM types for the tetris input front end.
// Optional echo port feature is selected with TETRIS_INPUT_ECHO_EN.
package tetris_input_pkg;

  typedef enum logic [3:0] {
    NONE      = 4'd0,
    IDLE      = 4'd1,
    PLAY      = 4'd2,
    PAUSE     = 4'd3,
    GAMEOVER  = 4'd4,
    LEFT      = 4'd5,
    RIGHT     = 4'd6,
    DOWN      = 4'd7,
    ROTATE    = 4'd8,
    HARD_DROP = 4'd9,
    HOLD      = 4'd10,
    NEW_GAME  = 4'd11
  } state_type;

  typedef enum logic {ARB_IDLE, ARB_GAP} arb_state_e;

  typedef enum logic [1:0] {REL, HELD, RPT} rpt_state_e;

  localparam int unsigned NUM_BTN = 4;

  localparam logic [7:0] KEY_A     = 8'h61;
  localparam logic [7:0] KEY_D     = 8'h64;
  localparam logic [7:0] KEY_S     = 8'h73;
  localparam logic [7:0] KEY_W     = 8'h77;
  localparam logic [7:0] KEY_SPACE = 8'h20;
  localparam logic [7:0] KEY_C     = 8'h63;
  localparam logic [7:0] KEY_P     = 8'h70;
  localparam logic [7:0] KEY_N     = 8'h6e;
  localparam logic [7:0] KEY_G     = 8'h67;

  // Case-insensitive ASCII to command; unmapped bytes give NONE.
  function automatic state_type key_to_cmd(input logic [7:0] b);
    logic [7:0] lc;
    lc = (b >= 8'h41 && b <= 8'h5a) ? (b | 8'h20) : b;
    case (lc)
      KEY_A:     return LEFT;
      KEY_D:     return RIGHT;
      KEY_S:     return DOWN;
      KEY_W:     return ROTATE;
      KEY_SPACE: return HARD_DROP;
      KEY_C:     return HOLD;
      KEY_P:     return PAUSE;
      KEY_N:     return NEW_GAME;
      default:   return NONE;
    endcase
  endfunction

  function automatic logic [7:0] cmd_to_key(input state_type cmd);
    case (cmd)
      LEFT:      return KEY_A;
      RIGHT:     return KEY_D;
      DOWN:      return KEY_S;
      ROTATE:    return KEY_W;
      HARD_DROP: return KEY_SPACE;
      HOLD:      return KEY_C;
      PAUSE:     return KEY_P;
      NEW_GAME:  return KEY_N;
      default:   return 8'h00;
    endcase
  endfunction

  function automatic state_type btn_to_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    return RIGHT;
      2'd1:    return DOWN;
      2'd2:    return LEFT;
      default: return ROTATE;
    endcase
  endfunction

  function automatic logic cmd_allowed(input state_type cmd, input state_type st);
    case (st)
      PLAY:    return 1'b1;
      PAUSE:   return (cmd == PAUSE) || (cmd == NEW_GAME);
      default: return cmd == NEW_GAME;
    endcase
  endfunction

endpackage

// File: rtl/tetris_input_if.sv
// UART byte, game state and command stream between the input block and the game core.
// Echo signals exist only when TETRIS_INPUT_ECHO_EN is defined.
interface tetris_input_if;
  import tetris_input_pkg::*;

  logic [7:0] rx_data;
  logic       rx_valid;
  state_type  state;
  state_type  control;
  logic [7:0] cmd_count;
`ifdef TETRIS_INPUT_ECHO_EN
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport slave  (input rx_data, rx_valid, state, tx_ready,
                  output control, cmd_count, tx_data, tx_valid);
  modport master (output rx_data, rx_valid, state, tx_ready,
                  input control, cmd_count, tx_data, tx_valid);
`else
  modport slave  (input rx_data, rx_valid, state, output control, cmd_count);
  modport master (output rx_data, rx_valid, state, input control, cmd_count);
`endif
endinterface

// File: rtl/tetris_input_btn_repeat.sv
// One button: 2-FF synchronizer, stability debounce and press/auto-repeat request FSM.
module tetris_input_btn_repeat
  import tetris_input_pkg::*;
#(
  parameter int unsigned DEB_CYC       = 500000,
  parameter int unsigned REPEAT_DELAY  = 12500000,
  parameter int unsigned REPEAT_PERIOD = 5000000,
  parameter bit          REPEAT_EN     = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_raw,
  output logic req_c
);

  localparam int unsigned DW   = $clog2(DEB_CYC) + 1;
  localparam int unsigned TMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned TW   = $clog2(TMAX) + 1;

  logic          sync1_q, sync2_q;
  logic          deb_q, deb_d;
  logic [DW-1:0] deb_cnt_q, deb_cnt_d;
  rpt_state_e    state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      deb_q     <= 1'b0;
      deb_cnt_q <= '0;
      state_q   <= REL;
      tmr_q     <= '0;
    end else begin
      sync1_q   <= btn_raw;
      sync2_q   <= sync1_q;
      deb_q     <= deb_d;
      deb_cnt_q <= deb_cnt_d;
      state_q   <= state_d;
      tmr_q     <= tmr_d;
    end
  end

  // Level flips only after DEB_CYC consecutive cycles of disagreement.
  always_comb begin
    deb_d     = deb_q;
    deb_cnt_d = deb_cnt_q;
    if (sync2_q == deb_q) begin
      deb_cnt_d = '0;
    end else if (deb_cnt_q == DW'(DEB_CYC - 1)) begin
      deb_d     = sync2_q;
      deb_cnt_d = '0;
    end else begin
      deb_cnt_d = deb_cnt_q + DW'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    req_c   = 1'b0;
    case (state_q)
      REL: begin
        if (deb_q) begin
          state_d = HELD;
          tmr_d   = '0;
          req_c   = 1'b1;
        end
      end
      HELD: begin
        if (!deb_q) begin
          state_d = REL;
        end else if (REPEAT_EN && tmr_q == TW'(REPEAT_DELAY - 1)) begin
          state_d = RPT;
          tmr_d   = '0;
          req_c   = 1'b1;
        end else if (REPEAT_EN) begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      RPT: begin
        if (!deb_q) begin
          state_d = REL;
        end else if (tmr_q == TW'(REPEAT_PERIOD - 1)) begin
          tmr_d = '0;
          req_c = 1'b1;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      default: state_d = REL;
    endcase
  end

endmodule

// File: rtl/tetris_input.sv
// Tetris command source: buttons, UART keys and gravity merged into a spaced, state-gated pulse stream.
// Define TETRIS_INPUT_ECHO_EN to add the tx_data/tx_valid/tx_ready key echo.
module tetris_input
  import tetris_input_pkg::*;
#(
  parameter int unsigned DEB_CYC       = 500000,
  parameter int unsigned REPEAT_DELAY  = 12500000,
  parameter int unsigned REPEAT_PERIOD = 5000000,
  parameter int unsigned GRAVITY_CYC   = 25000000,
  parameter int unsigned CMD_GAP       = 64
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_BTN-1:0] usr_btn,
  tetris_input_if.slave      bus
);

  localparam int unsigned GW  = $clog2(GRAVITY_CYC) + 1;
  localparam int unsigned GPW = $clog2(CMD_GAP) + 1;

  logic [NUM_BTN-1:0] req_c;
  state_type          st;
  state_type          rx_cmd;

  arb_state_e         arb_q, arb_d;
  logic [GPW-1:0]     gap_q, gap_d;
  state_type          control_q, control_d;
  logic [7:0]         cmd_count_q, cmd_count_d;
  logic [NUM_BTN-1:0] btn_pend_q, btn_pend_d;
  state_type          uart_q, uart_d;
  logic               grav_pend_q, grav_pend_d;
  logic [GW-1:0]      grav_cnt_q, grav_cnt_d;

  logic [NUM_BTN-1:0] btn_allow, btn_elig, issue_btn;
  logic               issue_uart, issue_grav, grav_hit;

  for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
    tetris_input_btn_repeat #(
      .DEB_CYC      (DEB_CYC),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD),
      .REPEAT_EN    (gi != 3)
    ) u_btn (
      .clk    (clk),
      .reset_n(reset_n),
      .btn_raw(usr_btn[gi]),
      .req_c  (req_c[gi])
    );
  end

  assign st     = bus.state;
  assign rx_cmd = key_to_cmd(bus.rx_data);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      arb_q       <= ARB_IDLE;
      gap_q       <= '0;
      control_q   <= NONE;
      cmd_count_q <= 8'd0;
      btn_pend_q  <= '0;
      uart_q      <= NONE;
      grav_pend_q <= 1'b0;
      grav_cnt_q  <= '0;
    end else begin
      arb_q       <= arb_d;
      gap_q       <= gap_d;
      control_q   <= control_d;
      cmd_count_q <= cmd_count_d;
      btn_pend_q  <= btn_pend_d;
      uart_q      <= uart_d;
      grav_pend_q <= grav_pend_d;
      grav_cnt_q  <= grav_cnt_d;
    end
  end

  // Arbiter, pending capture with state gating, and gravity timer.
  always_comb begin
    arb_d       = arb_q;
    gap_d       = gap_q;
    control_d   = NONE;
    cmd_count_d = cmd_count_q;
    issue_uart  = 1'b0;
    issue_btn   = '0;
    issue_grav  = 1'b0;
    grav_hit    = 1'b0;
    grav_cnt_d  = grav_cnt_q;
    uart_d      = uart_q;

    for (int i = 0; i < NUM_BTN; i++) begin
      btn_allow[i] = cmd_allowed(btn_to_cmd(2'(i)), st);
      btn_elig[i]  = btn_pend_q[i] & btn_allow[i];
    end

    case (arb_q)
      ARB_IDLE: begin
        if (uart_q != NONE && cmd_allowed(uart_q, st)) begin
          issue_uart = 1'b1;
          control_d  = uart_q;
        end else if (|btn_elig) begin
          issue_btn = btn_elig & (~btn_elig + NUM_BTN'(1));
          for (int i = 0; i < NUM_BTN; i++) begin
            if (issue_btn[i]) control_d = btn_to_cmd(2'(i));
          end
        end else if (grav_pend_q && st == PLAY) begin
          issue_grav = 1'b1;
          control_d  = DOWN;
        end
        if (control_d != NONE) begin
          arb_d       = ARB_GAP;
          gap_d       = '0;
          cmd_count_d = cmd_count_q + 8'd1;
        end
      end
      ARB_GAP: begin
        if (gap_q == GPW'(CMD_GAP - 1)) arb_d = ARB_IDLE;
        else                            gap_d = gap_q + GPW'(1);
      end
      default: arb_d = ARB_IDLE;
    endcase

    // A request arriving with its own issue re-arms the flag.
    btn_pend_d = (btn_pend_q & ~issue_btn & btn_allow) | (req_c & btn_allow);

    if (bus.rx_valid && rx_cmd != NONE && cmd_allowed(rx_cmd, st)) begin
      uart_d = rx_cmd;
    end else if (issue_uart || !cmd_allowed(uart_q, st)) begin
      uart_d = NONE;
    end

    if (st != PLAY) begin
      grav_cnt_d = '0;
    end else if (control_d == DOWN || control_d == HARD_DROP) begin
      grav_cnt_d = '0;
    end else if (grav_cnt_q == GW'(GRAVITY_CYC - 1)) begin
      grav_cnt_d = '0;
      grav_hit   = 1'b1;
    end else begin
      grav_cnt_d = grav_cnt_q + GW'(1);
    end
    grav_pend_d = (grav_pend_q & ~issue_grav & (st == PLAY)) | grav_hit;
  end

  assign bus.control   = control_q;
  assign bus.cmd_count = cmd_count_q;

`ifdef TETRIS_INPUT_ECHO_EN
  logic [7:0] tx_data_q, tx_data_d;
  logic       tx_valid_q, tx_valid_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
    end else begin
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
    end
  end

  // Single-entry echo buffer; a new command overwrites an unsent one.
  always_comb begin
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    if (control_d != NONE) begin
      tx_data_d  = issue_grav ? KEY_G : cmd_to_key(control_d);
      tx_valid_d = 1'b1;
    end else if (bus.tx_ready) begin
      tx_valid_d = 1'b0;
    end
  end

  assign bus.tx_data  = tx_data_q;
  assign bus.tx_valid = tx_valid_q;
`endif

endmodule

// File: tb/tb_tetris_input.sv
// Randomized and directed bench for tetris_input against a cycle-level behavioural model.
module tb_tetris_input;
  import tetris_input_pkg::*;

  localparam int DEB  = 4;
  localparam int RD   = 40;
  localparam int RP   = 10;
  localparam int GRAV = 100;
  localparam int GAP  = 3;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] usr_btn = 4'd0;

  tetris_input_if bus ();

  tetris_input #(
    .DEB_CYC(DEB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP),
    .GRAVITY_CYC(GRAV), .CMD_GAP(GAP)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .usr_btn(usr_btn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;
  int          cyc = 0;
  int          t0 = 0;
  int          iss_cyc[$];
  state_type   iss_cmd[$];

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  bit        m_pipe [4][2];
  bit        m_win  [4][DEB];
  bit        m_deb  [4];
  int        m_age  [4];
  bit        m_bpend[4];
  state_type m_uart;
  bit        m_grav;
  int        m_gcnt;
  int        m_gap;
  state_type m_ctrl;
  int        m_cnt;

  function automatic bit ok(input state_type c, input state_type s);
    if (s == PLAY) return 1'b1;
    if (s == PAUSE) return c == PAUSE || c == NEW_GAME;
    return c == NEW_GAME;
  endfunction

  function automatic state_type key(input logic [7:0] b);
    case (b)
      8'h61, 8'h41: return LEFT;
      8'h64, 8'h44: return RIGHT;
      8'h73, 8'h53: return DOWN;
      8'h77, 8'h57: return ROTATE;
      8'h20:        return HARD_DROP;
      8'h63, 8'h43: return HOLD;
      8'h70, 8'h50: return PAUSE;
      8'h6e, 8'h4e: return NEW_GAME;
      default:      return NONE;
    endcase
  endfunction

  function automatic state_type bcmd(input int i);
    case (i)
      0: return RIGHT;
      1: return DOWN;
      2: return LEFT;
      default: return ROTATE;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_pipe[i][0] = 0; m_pipe[i][1] = 0;
      for (int k = 0; k < DEB; k++) m_win[i][k] = 0;
      m_deb[i] = 0; m_age[i] = -1; m_bpend[i] = 0;
    end
    m_uart = NONE; m_grav = 0; m_gcnt = 0; m_gap = 0; m_ctrl = NONE; m_cnt = 0;
  endtask

  task automatic model_step();
    bit        req[4];
    bit        all_diff, prev, a, hit;
    int        src;
    state_type s, rc, nc;
    if (!reset_n) begin
      model_reset();
      return;
    end
    s = bus.state;
    // buttons: synchronized sample window, debounced level, hold age
    for (int i = 0; i < 4; i++) begin
      prev = m_deb[i];
      for (int k = DEB - 1; k > 0; k--) m_win[i][k] = m_win[i][k-1];
      m_win[i][0] = m_pipe[i][1];
      all_diff = 1;
      for (int k = 0; k < DEB; k++) if (m_win[i][k] == prev) all_diff = 0;
      req[i] = 0;
      if (!prev) m_age[i] = -1;
      else begin
        m_age[i]++;
        req[i] = (m_age[i] == 0) ||
                 (i != 3 && m_age[i] >= RD && ((m_age[i] - RD) % RP) == 0);
      end
      if (all_diff) m_deb[i] = ~prev;
      m_pipe[i][1] = m_pipe[i][0];
      m_pipe[i][0] = usr_btn[i];
    end
    // arbitration
    src = -1;
    nc  = NONE;
    if (m_gap == 0) begin
      if (m_uart != NONE && ok(m_uart, s)) src = 0;
      for (int i = 0; i < 4; i++) if (src < 0 && m_bpend[i] && ok(bcmd(i), s)) src = 1 + i;
      if (src < 0 && m_grav && s == PLAY) src = 5;
    end
    if (src == 0) nc = m_uart;
    else if (src == 5) nc = DOWN;
    else if (src > 0) nc = bcmd(src - 1);
    if (src >= 0) begin
      m_cnt = (m_cnt + 1) % 256;
      m_gap = GAP;
    end else if (m_gap > 0) m_gap--;
    m_ctrl = nc;
    // pending capture
    for (int i = 0; i < 4; i++) begin
      a = ok(bcmd(i), s);
      m_bpend[i] = (m_bpend[i] && a && src != 1 + i) || (req[i] && a);
    end
    rc = key(bus.rx_data);
    if (bus.rx_valid && rc != NONE && ok(rc, s)) m_uart = rc;
    else if (src == 0 || !ok(m_uart, s)) m_uart = NONE;
    // gravity
    hit = 0;
    if (s != PLAY) m_gcnt = 0;
    else if (nc == DOWN || nc == HARD_DROP) m_gcnt = 0;
    else if (m_gcnt == GRAV - 1) begin m_gcnt = 0; hit = 1; end
    else m_gcnt++;
    m_grav = (m_grav && s == PLAY && src != 5) || hit;
  endtask

  always begin
    @(posedge clk);
    cyc++;
    model_step();
    #1;
    check_eq("control", 32'(bus.control), 32'(m_ctrl));
    check_eq("cmd_count", 32'(bus.cmd_count), 32'(m_cnt));
    if (bus.control != NONE) begin
      iss_cyc.push_back(cyc);
      iss_cmd.push_back(bus.control);
    end
  end

  // ---------------- stimulus ----------------
  function automatic state_type got_cmd(input int k);
    if (k < iss_cmd.size()) return iss_cmd[k];
    return NONE;
  endfunction

  function automatic int got_cyc(input int k);
    if (k < iss_cyc.size()) return iss_cyc[k];
    return -1;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic do_reset(input state_type s);
    @(negedge clk);
    reset_n = 1'b0;
    usr_btn = 4'd0;
    bus.rx_valid = 1'b0;
    bus.state = s;
    #1;
    check_eq("rst_control", 32'(bus.control), 32'(NONE));
    check_eq("rst_count", 32'(bus.cmd_count), 0);
    tick(2);
    reset_n = 1'b1;
    iss_cyc.delete();
    iss_cmd.delete();
    t0 = cyc;
  endtask

  logic [7:0] keys [16] = '{8'h61, 8'h41, 8'h64, 8'h44, 8'h73, 8'h53, 8'h77, 8'h57,
                            8'h20, 8'h63, 8'h43, 8'h70, 8'h50, 8'h6e, 8'h4e, 8'h78};

  initial begin
    model_reset();
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    bus.state    = IDLE;
    tick(3);

    // LEFT held 70 cycles: first press plus three repeats
    do_reset(PLAY);
    usr_btn[2] = 1'b1;
    tick(70);
    usr_btn[2] = 1'b0;
    tick(20);
    check_eq("left_hold_count", 32'(bus.cmd_count), 4);
    check_eq("left_first_lat", 32'(got_cyc(0) - t0), 2 + DEB + 2);
    check_eq("left_rpt_spacing", 32'(got_cyc(2) - got_cyc(1)), RP);

    // 2-cycle glitch is filtered
    do_reset(PLAY);
    usr_btn[2] = 1'b1;
    tick(2);
    usr_btn[2] = 1'b0;
    tick(20);
    check_eq("glitch_count", 32'(bus.cmd_count), 0);

    // newer UART byte overwrites an unissued one
    do_reset(PLAY);
    send(8'h77);
    send(8'h41);
    send(8'h44);
    tick(10);
    check_eq("ovr_count", 32'(bus.cmd_count), 2);
    check_eq("ovr_second", 32'(got_cmd(1)), 32'(RIGHT));

    // IDLE: only NEW_GAME passes
    do_reset(IDLE);
    send(8'h61);
    send(8'h6e);
    tick(8);
    check_eq("idle_count", 32'(bus.cmd_count), 1);
    check_eq("idle_cmd", 32'(got_cmd(0)), 32'(NEW_GAME));

    // gravity and HARD_DROP restart
    do_reset(PLAY);
    tick(150);
    send(8'h20);
    tick(150);
    check_eq("grav_count", 32'(bus.cmd_count), 3);
    check_eq("grav_first", 32'(got_cyc(0) - t0), GRAV + 1);
    check_eq("grav_hd", 32'(got_cmd(1)), 32'(HARD_DROP));
    check_eq("grav_after_hd", 32'(got_cyc(2) - got_cyc(1)), GRAV + 1);

    // UART DOWN and button RIGHT captured together
    do_reset(PLAY);
    usr_btn[0] = 1'b1;
    tick(6);
    send(8'h73);
    tick(12);
    usr_btn[0] = 1'b0;
    tick(12);
    check_eq("sim_first", 32'(got_cmd(0)), 32'(DOWN));
    check_eq("sim_second", 32'(got_cmd(1)), 32'(RIGHT));
    check_eq("sim_spacing", 32'(got_cyc(1) - got_cyc(0)), GAP + 1);
    check_eq("sim_count", 32'(bus.cmd_count), 2);

    // reset in the gap with a pending key
    do_reset(PLAY);
    send(8'h73);
    send(8'h61);
    do_reset(PLAY);
    tick(10);
    check_eq("gaprst_count", 32'(bus.cmd_count), 0);
    check_eq("gaprst_issues", 32'(iss_cmd.size()), 0);

    // randomized traffic
    do_reset(PLAY);
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      reset_n = 1'b1;
      bus.rx_valid = 1'b0;
      if ($urandom_range(0, 49) == 0) begin
        case ($urandom_range(0, 5))
          0: bus.state = IDLE;
          1: bus.state = PAUSE;
          2: bus.state = GAMEOVER;
          default: bus.state = PLAY;
        endcase
      end
      for (int b = 0; b < 4; b++) if ($urandom_range(0, 24) == 0) usr_btn[b] = ~usr_btn[b];
      if ($urandom_range(0, 7) == 0) begin
        bus.rx_valid = 1'b1;
        bus.rx_data  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : keys[$urandom_range(0, 15)];
      end
      if ($urandom_range(0, 999) == 0) reset_n = 1'b0;
    end
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
